stack_port_arbiter: RTL and testbench
=====================================

// Module: stack_port_arbiter
// PURPOSE
//   Shares one 16-bit LIFO stack (32 slots) between N requesters (CPU data path, call/return unit, ...).
//   Round-robin arbitration, req/ack handshake per requester, one-cycle enable pulse per stack op.
//   Blocks illegal ops (push-when-full, pop-when-empty) and reports them as errors.
//   Keeps a shadow occupancy count. Sits between the requesters and the stack instance.
// PARAMETERS
//   NREQ   2   number of requesters (1..4)
//   DW     16  data width, must match the stack
//   DEPTH  32  stack slots; count width CW = $clog2(DEPTH+1)
// PORTS
//   clk        in   1        clock, all logic on posedge
//   rst        in   1        synchronous, active-high reset
//   clr        in   1        1-cycle pulse: clear the stack (sampled in IDLE only)
//   req        in   NREQ     request per requester; hold high until ack
//   req_rw     in   NREQ     per requester: 1 = push, 0 = pop
//   req_din    in   NREQ*DW  push data, requester i in bits [i*DW +: DW]
//   ack        out  NREQ     one-hot, 1-cycle completion pulse
//   err        out  1        valid with ack: op refused (full on push / empty on pop)
//   rdata      out  DW       pop data, valid with ack on a successful pop
//   count      out  CW       shadow occupancy, 0..DEPTH
//   busy       out  1        high in any state other than IDLE
//   stk_en     out  1        stack enable
//   stk_rst    out  1        stack clear
//   stk_rw     out  1        stack rw: 1 = write (push), 0 = read (pop)
//   stk_din    out  DW       stack write data
//   stk_dout   in   DW       stack read data, registered by the stack
//   stk_empty  in   1        stack empty flag
//   stk_full   in   1        stack full flag
// BEHAVIOUR
//   Reset (rst=1): drive stk_en=1 and stk_rst=1 combinationally so the stack clears on the same edge.
//     On that edge: state=IDLE, ack=0, err=0, rdata=0, count=0, busy=0, rr_ptr=NREQ-1.
//   FSM states: IDLE -> ISSUE -> DONE -> IDLE, plus IDLE -> CLEAR -> IDLE.
//   IDLE
//     clr=1 has priority over all requests -> CLEAR.
//     Otherwise, if any req: grant the first requester with req set, searching (rr_ptr+1) mod NREQ upward.
//     Latch gnt index, rw and din into internal registers -> ISSUE.
//     Later changes on req_rw / req_din have no effect on the granted op.
//   CLEAR
//     stk_en=1, stk_rst=1 for exactly 1 cycle; count <= 0. No ack is issued -> IDLE.
//   ISSUE
//     legal = rw ? !stk_full : !stk_empty.
//     If legal: stk_en=1, stk_rw=rw, stk_din=latched din.
//       Push: count+1. Pop: count-1.
//     If not legal: stk_en=0, err_q <= 1, count unchanged.
//     -> DONE.
//   DONE
//     ack[gnt]=1 and err=err_q for 1 cycle.
//     On a successful pop, rdata=stk_dout. rdata holds its value until the next successful pop.
//     rr_ptr <= gnt -> IDLE.
//   Latency
//     req seen in IDLE at cycle t: stack edge at end of t+1, ack at t+2.
//     Max throughput is one op per 3 cycles. The requester drops req in the cycle after ack.
//   In every state except ISSUE/CLEAR, and outside reset: stk_en=0, stk_rst=0.
//   Requester protocol
//     A req dropped before it is granted is simply not served.
//     A req still high in the cycle after ack may be re-granted if round robin reaches it.
//   Boundaries
//     count saturates logically at DEPTH and 0 (guaranteed by the legal check).
//     Mismatch between count and the stack flags is an assertion failure.
//   rst mid-operation (ISSUE/DONE): op abandoned, no ack, stack cleared.
// STRUCTURE
//   Shared package stack_pkg: DW, DEPTH, CW, state enum {IDLE, CLEAR, ISSUE, DONE}.
//   One sub-module: rr_arbiter (req, ptr -> one-hot gnt + valid), combinational, parameterised by NREQ.
//   FSM, latches and count live in this module. The stack is instantiated by the parent.
// TESTING (bench instantiates the real stack)
//   1. Push 0xBEEF via req0, then pop via req0 -> ack0 at t+2 each; pop returns rdata=0xBEEF, err=0, count 1->0.
//   2. req0 and req1 both held high, push each -> grants alternate 0,1,0,1; 4 acks; count=4.
//   3. Pop on an empty stack -> ack with err=1, stk_en never asserted, count=0, rdata unchanged.
//   4. 32 pushes, then a 33rd -> 33rd gets err=1; count=32; next pop returns the 32nd value.
//   5. clr pulse in IDLE while req1 pending -> CLEAR first, count=0, stk_empty=1; req1 served afterwards.
//   6. Assert rst during ISSUE of a push -> no ack, count=0, stack empty, busy=0 the next cycle.

Source files
------------

// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
//  Package : stack_pkg
//  Shared widths and FSM state encoding for the stack port arbiter.
//  Revision: 1.0  initial release
// ============================================================================
package stack_pkg;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_port_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter
//  Combinational round-robin picker. Searches upward starting at (ptr+1)
//  mod NREQ and returns the first requester found as a one-hot grant.
//  Ports   : req_i   - request vector
//            ptr_i   - index of the most recently served requester
//            gnt_o   - one-hot grant
//            valid_o - at least one request present
//  Revision: 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o
);

  logic [PW-1:0] idx_w;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx_w   = '0;
    // Offsets 1..NREQ visit every requester once, ending on ptr itself so
    // a lone requester can be served back to back.
    for (int k = 1; k <= NREQ; k++) begin
      idx_w = PW'((int'(ptr_i) + k) % NREQ);
      if (!valid_o && req_i[idx_w]) begin
        gnt_o[idx_w] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/stack_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : stack_port_arbiter
//  Shares one LIFO stack between NREQ requesters with round-robin
//  arbitration, req/ack handshake, illegal-op blocking and a shadow count.
//  Ports   : clk, rst              - clock, synchronous active-high reset
//            clr                   - clear request (honoured in IDLE)
//            req/req_rw/req_din    - per-requester request, op, push data
//            ack/err/rdata         - completion pulse, refusal flag, pop data
//            count/busy            - shadow occupancy, FSM not idle
//            stk_en/stk_rst/stk_rw/stk_din   - stack control
//            stk_dout/stk_empty/stk_full     - stack status and read data
//  Revision: 1.0  initial release
// ============================================================================
module stack_port_arbiter #(
  parameter  int NREQ  = 2,
  parameter  int DW    = stack_pkg::DW,
  parameter  int DEPTH = stack_pkg::DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_rw,
  input  logic [NREQ*DW-1:0] req_din,
  output logic [NREQ-1:0]  ack,
  output logic             err,
  output logic [DW-1:0]    rdata,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             stk_en,
  output logic             stk_rst,
  output logic             stk_rw,
  output logic [DW-1:0]    stk_din,
  input  logic [DW-1:0]    stk_dout,
  input  logic             stk_empty,
  input  logic             stk_full
);

  import stack_pkg::*;

  state_e          state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   gnt_idx_q;
  logic            rw_q;
  logic [DW-1:0]   din_q;
  logic [NREQ-1:0] ack_q;
  logic            err_q;
  logic [DW-1:0]   rdata_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  logic [NREQ-1:0] gnt_w;
  logic            gnt_valid_w;
  logic [PW-1:0]   gnt_idx_w;
  logic            legal_w;
  logic            pop_done_w;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (gnt_w),
    .valid_o (gnt_valid_w)
  );

  always_comb begin
    gnt_idx_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_w[i]) gnt_idx_w = PW'(i);
    end
  end

  assign legal_w = rw_q ? ~stk_full : ~stk_empty;

  always_comb begin
    count_d = count_q;
    if (state_q == ISSUE && legal_w) begin
      count_d = rw_q ? count_q + CW'(1) : count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= PW'(NREQ - 1);
      gnt_idx_q <= '0;
      rw_q      <= 1'b0;
      din_q     <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q <= CLEAR;
          end else if (gnt_valid_w) begin
            // Op parameters are frozen here; the requester may change its
            // inputs afterwards without affecting this transaction.
            gnt_idx_q <= gnt_idx_w;
            rw_q      <= req_rw[gnt_idx_w];
            din_q     <= req_din[int'(gnt_idx_w)*DW +: DW];
            state_q   <= ISSUE;
          end
        end
        CLEAR: begin
          count_q <= '0;
          state_q <= IDLE;
        end
        ISSUE: begin
          count_q          <= count_d;
          err_q            <= ~legal_w;
          ack_q[gnt_idx_q] <= 1'b1;
          state_q          <= DONE;
        end
        DONE: begin
          ack_q    <= '0;
          err_q    <= 1'b0;
          if (pop_done_w) rdata_q <= stk_dout;
          rr_ptr_q <= gnt_idx_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The stack registers its read data on the pop edge, so it is only
  // visible in DONE; pass it straight through then and hold it afterwards.
  assign pop_done_w = (state_q == DONE) & ~rw_q & ~err_q;
  assign rdata      = pop_done_w ? stk_dout : rdata_q;

  assign ack   = ack_q;
  assign err   = err_q;
  assign count = count_q;
  assign busy  = (state_q != IDLE);

  // Reset forces a stack clear on the same edge that resets this block.
  assign stk_en  = rst | (state_q == CLEAR) | ((state_q == ISSUE) & legal_w);
  assign stk_rst = rst | (state_q == CLEAR);
  assign stk_rw  = ~rst & (state_q == ISSUE) & rw_q;
  assign stk_din = din_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (stk_empty == (count_q == '0));
      assert (stk_full  == (count_q == CW'(DEPTH)));
    end
  end

endmodule : stack_port_arbiter
`default_nettype wire

// File: tb/tb_stack_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_stack_port_arbiter
//  Self-checking bench: directed scenarios with literal expectations plus
//  randomized requesters, checked every cycle against a transaction model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_stack_port_arbiter;

  localparam int NREQ  = 2;
  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  req_rw;
  logic [NREQ*DW-1:0] req_din;
  logic [NREQ-1:0]  ack;
  logic             err;
  logic [DW-1:0]    rdata;
  logic [CW-1:0]    count;
  logic             busy;
  logic             stk_en, stk_rst, stk_rw;
  logic [DW-1:0]    stk_din, stk_dout;
  logic             stk_empty, stk_full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stack_port_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .req_rw(req_rw),
    .req_din(req_din), .ack(ack), .err(err), .rdata(rdata), .count(count),
    .busy(busy), .stk_en(stk_en), .stk_rst(stk_rst), .stk_rw(stk_rw),
    .stk_din(stk_din), .stk_dout(stk_dout), .stk_empty(stk_empty),
    .stk_full(stk_full)
  );

  // Behavioural LIFO standing in for the stack instance.
  logic [DW-1:0] smem [DEPTH];
  int            sp    = 0;
  logic [DW-1:0] sdout = '0;

  always @(posedge clk) begin
    if (stk_en) begin
      if (stk_rst) begin
        sp <= 0;
      end else if (stk_rw) begin
        if (sp < DEPTH) begin
          smem[sp] <= stk_din;
          sp       <= sp + 1;
        end
      end else if (sp > 0) begin
        sdout <= smem[sp-1];
        sp    <= sp - 1;
      end
    end
  end
  assign stk_dout  = sdout;
  assign stk_empty = (sp == 0);
  assign stk_full  = (sp == DEPTH);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Transaction model: schedules each granted op by cycle number
  // (issue one cycle after grant, ack two after) and a software queue
  // as the stack contents.
  // ------------------------------------------------------------------
  int            cyc       = 0;
  bit            started   = 0;
  int            idle_at, issue_cyc, ack_cyc, clear_cyc, mptr, op_g;
  bit            op_rw, op_err;
  logic [DW-1:0] op_din, op_pop, rdata_hold;
  logic [DW-1:0] mq[$];

  initial begin
    logic [NREQ-1:0] e_ack;
    bit e_err, e_en, e_srst, e_busy, found;
    int g;
    forever begin
      @(negedge clk);
      if (rst) begin
        started    = 1;
        idle_at    = cyc + 1;
        issue_cyc  = -1;
        ack_cyc    = -1;
        clear_cyc  = -1;
        mptr       = NREQ - 1;
        rdata_hold = '0;
        mq.delete();
        chk("rst_stk_en", 32'(stk_en), 32'd1);
        chk("rst_stk_rst", 32'(stk_rst), 32'd1);
      end else if (started) begin
        e_busy = (cyc != idle_at);
        e_ack  = '0;
        e_err  = 0;
        e_en   = 0;
        e_srst = 0;
        if (cyc == clear_cyc) begin
          e_en   = 1;
          e_srst = 1;
        end
        if (cyc == issue_cyc) begin
          op_err = op_rw ? (mq.size() >= DEPTH) : (mq.size() == 0);
          if (!op_err && !op_rw) op_pop = mq[$];
          e_en = !op_err;
        end
        if (cyc == ack_cyc) begin
          e_ack[op_g] = 1'b1;
          e_err       = op_err;
          if (!op_rw && !op_err) rdata_hold = op_pop;
        end
        chk("m_busy", 32'(busy), 32'(e_busy));
        chk("m_ack", 32'(ack), 32'(e_ack));
        chk("m_err", 32'(err), 32'(e_err));
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_rdata", 32'(rdata), 32'(rdata_hold));
        chk("m_stk_en", 32'(stk_en), 32'(e_en));
        chk("m_stk_rst", 32'(stk_rst), 32'(e_srst));
        if (cyc == issue_cyc && e_en) begin
          chk("m_stk_rw", 32'(stk_rw), 32'(op_rw));
          if (op_rw) chk("m_stk_din", 32'(stk_din), 32'(op_din));
        end
        // State seen by the stack after this edge.
        if (cyc == issue_cyc && !op_err) begin
          if (op_rw) mq.push_back(op_din);
          else void'(mq.pop_back());
        end
        if (cyc == clear_cyc) mq.delete();
        if (cyc == idle_at) begin
          if (clr) begin
            clear_cyc = cyc + 1;
            idle_at   = cyc + 2;
          end else begin
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
              g = (mptr + k) % NREQ;
              if (!found && req[g]) begin
                found = 1;
                op_g  = g;
              end
            end
            if (found) begin
              op_rw     = req_rw[op_g];
              op_din    = req_din[op_g*DW +: DW];
              issue_cyc = cyc + 1;
              ack_cyc   = cyc + 2;
              idle_at   = cyc + 3;
              mptr      = op_g;
            end else begin
              idle_at = cyc + 1;
            end
          end
        end
      end
      cyc++;
    end
  end

  // ------------------------------------------------------------------
  // Directed helpers. Callers sit just after a rising edge.
  // ------------------------------------------------------------------
  task automatic rst_pulse();
    rst = 1; req = '0; clr = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic do_op(input int i, input bit rw, input logic [DW-1:0] d,
                       output bit e, output logic [DW-1:0] rd,
                       output int lat, output int en_cnt, output int cnt);
    req[i] = 1'b1;
    req_rw[i] = rw;
    req_din[i*DW +: DW] = d;
    lat = -1; en_cnt = 0; e = 0; rd = '0; cnt = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (stk_en) en_cnt++;
      if (ack[i]) begin
        lat = n; e = err; rd = rdata; cnt = int'(count);
        break;
      end
    end
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  initial begin
    bit            e;
    logic [DW-1:0] rd;
    int            lat, en_cnt, cnt, n_ack, extra;
    int            ord[4];
    int            ack_t[4];
    bit            err_any, lat_bad;
    logic [NREQ-1:0] la;
    int            tmo;

    rst = 1; clr = 0; req = '0; req_rw = '0; req_din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    @(posedge clk); #1;

    // Push then pop a single value.
    do_op(0, 1'b1, 16'hBEEF, e, rd, lat, en_cnt, cnt);
    chk("t1_push_lat", 32'(lat), 32'd2);
    chk("t1_push_err", 32'(e), 32'd0);
    chk("t1_push_count", 32'(cnt), 32'd1);
    do_op(0, 1'b0, 16'h0000, e, rd, lat, en_cnt, cnt);
    chk("t1_pop_lat", 32'(lat), 32'd2);
    chk("t1_pop_rdata", 32'(rd), 32'hBEEF);
    chk("t1_pop_err", 32'(e), 32'd0);
    chk("t1_pop_count", 32'(cnt), 32'd0);

    // Pop on empty: refused, stack untouched, rdata held.
    do_op(0, 1'b0, 16'h0000, e, rd, lat, en_cnt, cnt);
    chk("t3_err", 32'(e), 32'd1);
    chk("t3_stk_en_cnt", 32'(en_cnt), 32'd0);
    chk("t3_count", 32'(cnt), 32'd0);
    chk("t3_rdata_held", 32'(rd), 32'hBEEF);

    // Two requesters holding req: grants alternate starting at 0.
    rst_pulse();
    req = 2'b11; req_rw = 2'b11; req_din = {16'h2222, 16'h1111};
    n_ack = 0;
    for (int n = 0; n < 40 && n_ack < 4; n++) begin
      @(negedge clk);
      if (ack != '0) begin
        ord[n_ack]   = ack[1] ? 1 : 0;
        ack_t[n_ack] = n;
        n_ack++;
      end
    end
    @(posedge clk); #1;
    req = '0;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack != '0) extra++;
    end
    chk("t2_n_ack", 32'(n_ack), 32'd4);
    chk("t2_g0", 32'(ord[0]), 32'd0);
    chk("t2_g1", 32'(ord[1]), 32'd1);
    chk("t2_g2", 32'(ord[2]), 32'd0);
    chk("t2_g3", 32'(ord[3]), 32'd1);
    chk("t2_spacing", 32'(ack_t[1] - ack_t[0]), 32'd3);
    chk("t2_extra_acks", 32'(extra), 32'd0);
    chk("t2_count", 32'(count), 32'd4);
    @(posedge clk); #1;

    // Fill to 32, refuse the 33rd, pop returns the 32nd value.
    rst_pulse();
    err_any = 0; lat_bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      do_op(0, 1'b1, 16'h1000 + 16'(i), e, rd, lat, en_cnt, cnt);
      if (e) err_any = 1;
      if (lat != 2) lat_bad = 1;
    end
    chk("t4_fill_err", 32'(err_any), 32'd0);
    chk("t4_fill_lat", 32'(lat_bad), 32'd0);
    chk("t4_full_count", 32'(cnt), 32'd32);
    chk("t4_full_flag", 32'(stk_full), 32'd1);
    do_op(0, 1'b1, 16'hDEAD, e, rd, lat, en_cnt, cnt);
    chk("t4_33_err", 32'(e), 32'd1);
    chk("t4_33_en", 32'(en_cnt), 32'd0);
    chk("t4_33_count", 32'(cnt), 32'd32);
    do_op(0, 1'b0, 16'h0000, e, rd, lat, en_cnt, cnt);
    chk("t4_pop_rdata", 32'(rd), 32'h101F);
    chk("t4_pop_count", 32'(cnt), 32'd31);

    // Clear pulse has priority over a pending request.
    clr = 1; req[1] = 1; req_rw[1] = 1; req_din[DW +: DW] = 16'h5A5A;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("t5_stk_rst", 32'(stk_rst), 32'd1);
        chk("t5_no_ack", 32'(ack), 32'd0);
      end
      if (n == 2) begin
        chk("t5_count0", 32'(count), 32'd0);
        chk("t5_empty", 32'(stk_empty), 32'd1);
      end
      if (ack[1]) begin
        lat = n; e = err; cnt = int'(count);
        break;
      end
      @(posedge clk); #1;
      clr = 0;
    end
    chk("t5_req1_lat", 32'(lat), 32'd4);
    chk("t5_req1_err", 32'(e), 32'd0);
    chk("t5_req1_count", 32'(cnt), 32'd1);
    @(posedge clk); #1;
    req[1] = 0;

    // Reset during ISSUE abandons the op.
    req[0] = 1; req_rw[0] = 1; req_din[0 +: DW] = 16'h7777;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("t6_rst_en", 32'(stk_en), 32'd1);
    @(posedge clk); #1;
    rst = 0; req = '0;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(stk_empty), 32'd1);
    extra = 0;
    repeat (4) begin
      if (ack != '0) extra++;
      @(negedge clk);
    end
    chk("t6_no_ack", 32'(extra), 32'd0);
    @(posedge clk); #1;

    // Randomized requesters; the model checks every cycle.
    rst_pulse();
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      la = ack;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 1499) == 0);
      clr = !rst && ($urandom_range(0, 399) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && la[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i]    = 1;
            req_rw[i] = ($urandom_range(0, 99) < (((k / 300) % 2) ? 25 : 80));
            req_din[i*DW +: DW] = 16'($urandom);
          end
        end else if ($urandom_range(0, 7) == 0) begin
          req_din[i*DW +: DW] = 16'($urandom);
          req_rw[i] = ~req_rw[i];
        end
      end
    end
    rst = 0; clr = 0; req = '0;
    tmo = 0;
    while (busy && tmo < 10) begin
      @(posedge clk); #1;
      tmo++;
    end
    chk("drain_idle", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_stack_port_arbiter
`default_nettype wire
